spart_driver: RTL
=================

# spart_driver

Bus-master controller for the mini SPART. It sits on the processor side of the SPART bus interface and generates every `iocs`/`iorw`/`ioaddr`/`databus` cycle:
- After reset it programs the 16-bit baud divisor selected by the board switches.
- It then polls the status register and echoes each received byte back to the transmitter.
- It replaces a CPU in the standalone lab build.

## Interface
Parameters:
- none; divisor constants live in the shared package.

Ports:
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  reset; one clock, synchronous, active-high
- `br_cfg`  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400
- `databus_in`  in  8  read data returned by SPART (combinational on `iocs`/`iorw`/`ioaddr`)
- `iocs`  out  1  chip select, one cycle per access
- `iorw`  out  1  1=read, 0=write
- `ioaddr`  out  2  00=RX/TX buffer, 01=status, 10=DB low, 11=DB high
- `databus_out`  out  8  write data to SPART
- `rx_byte`  out  8  last byte read from RX buffer
- `echo_cnt`  out  8  count of completed TX writes
- `cfg_done`  out  1  high once both divisor bytes are written for the current `br_cfg`

## Operation
Status byte at `ioaddr`=01: bit0 = TBR (TX buffer ready), bit1 = RDA (RX data available); other bits ignored.

Divisors: 4800→0x0515, 9600→0x028A, 19200→0x0145, 38400→0x00A2.

FSM states:
- CFG_LOW: write divisor[7:0] to addr 10 → CFG_HIGH.
- CFG_HIGH: write divisor[15:8] to addr 11; latch `br_cfg` into `cfg_reg`; set `cfg_done` → POLL_RX.
- POLL_RX: read addr 01.
  - If bit1=1 → READ_RX.
  - Else if the registered `br_cfg` ≠ `cfg_reg` → clear `cfg_done` → CFG_LOW.
  - Else stay in POLL_RX.
- READ_RX: read addr 00; capture `databus_in` into `rx_byte` → POLL_TX.
- POLL_TX: read addr 01.
  - If bit0=1 → WRITE_TX.
  - Else stay in POLL_TX.
- WRITE_TX: write `rx_byte` to addr 00; `echo_cnt` += 1 (wraps 0xFF→0x00) → POLL_RX.

Every state issues exactly one access with `iocs`=1 for one cycle. `databus_out` is 0x00 on every read cycle.

Boundary rules:
- `br_cfg` change: checked only in POLL_RX. A byte already being echoed is always transmitted before reconfiguration.
- `br_cfg` changing during CFG_LOW/CFG_HIGH: the divisor in use is the one sampled when entering CFG_LOW, so the low and high bytes stay consistent. The mismatch is caught on the next POLL_RX.
- RDA and a config change in the same POLL_RX cycle: RDA wins.
- `rst` mid-operation (any state, including WRITE_TX): the FSM returns to CFG_LOW and the divisor is rewritten. A held byte is dropped; no partial write completes after reset.

Reset values:
- `iocs`=0, `iorw`=1, `ioaddr`=00, `databus_out`=0x00
- `rx_byte`=0x00, `echo_cnt`=0x00, `cfg_done`=0
- internal `cfg_reg`=00

## Timing
- All outputs are registered and change only on rising `clk`.
- `databus_in` is sampled at the rising edge that ends the access cycle.
- `br_cfg` passes through a two-flop synchronizer before comparison. This adds 2 cycles of latency before a switch change is seen.
- First edge with `rst`=0: outputs reflect CFG_LOW in cycle 1, CFG_HIGH in cycle 2, first POLL_RX in cycle 3. `cfg_done` is high from cycle 3.
- Minimum echo, status read with RDA=1 in cycle n: READ_RX in n+1, POLL_TX in n+2, WRITE_TX in n+3 if TBR=1, POLL_RX in n+4. `echo_cnt` updates at the end of n+3.
- TBR=0 holds the FSM in POLL_TX with no timeout. Each extra poll adds one cycle.

## Structure
- Package `spart_pkg`:
  - address constants `ADDR_BUF`/`ADDR_STAT`/`ADDR_DBL`/`ADDR_DBH`
  - status bit indices `STAT_TBR`=0, `STAT_RDA`=1
  - the four divisor constants and a `div_lookup(br_cfg)` function
  - the FSM state enum

  These are shared with `bus_interface` and the benches.
- No sub-module: the synchronizer and FSM stay in one file.

## Test plan
- Reset with `br_cfg`=01, release → cycle 1: `iocs`=1, `iorw`=0, `ioaddr`=10, data 0x8A. Cycle 2: `ioaddr`=11, data 0x02. Cycle 3: status read, `cfg_done`=1.
- Model returns status 0x03, then byte 0x41 → `rx_byte`=0x41, write 0x41 to addr 00 at n+3, `echo_cnt`=1.
- Status bit0=0 for 5 polls, then 1 → exactly 6 POLL_TX reads, then one write of the held byte.
- `br_cfg` changed 01→11 while in POLL_TX with byte 0x55 held → 0x55 written first. CFG_LOW/CFG_HIGH then write 0xA2/0x00, `cfg_done` low during reconfiguration.
- 256 echoes → `echo_cnt` wraps to 0x00.
- `rst` asserted during WRITE_TX → next cycle all outputs at reset values. After release the divisor sequence restarts; no stale TX write appears.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART bus definitions: register addresses, status bits, baud divisors, driver FSM states.
// Pure declarations, no timing or backpressure of its own.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int STAT_TBR = 0;
    localparam int STAT_RDA = 1;

    localparam logic [15:0] DIV_4800  = 16'h0515;
    localparam logic [15:0] DIV_9600  = 16'h028A;
    localparam logic [15:0] DIV_19200 = 16'h0145;
    localparam logic [15:0] DIV_38400 = 16'h00A2;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_CFG_LOW,
        ST_CFG_HIGH,
        ST_POLL_RX,
        ST_READ_RX,
        ST_POLL_TX,
        ST_WRITE_TX
    } state_e;

    function automatic logic [15:0] div_lookup(input logic [1:0] br_cfg);
        logic [15:0] div;
        case (br_cfg)
            2'b00:   div = DIV_4800;
            2'b01:   div = DIV_9600;
            2'b10:   div = DIV_19200;
            default: div = DIV_38400;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor, then echoes every received byte back out.
// One registered access per cycle; waits indefinitely on TBR/RDA status, no timeout.
module spart_driver
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic [7:0] databus_in,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] databus_out,
    output logic [7:0] rx_byte,
    output logic [7:0] echo_cnt,
    output logic       cfg_done
);

    // Switch synchronizer is left out of reset so a short reset still sees settled switches.
    logic [1:0] br_meta_q, br_sync_q;

    always_ff @(posedge clk) begin
        br_meta_q <= br_cfg;
        br_sync_q <= br_meta_q;
    end

    state_e      state_q, state_d;
    logic [1:0]  cfg_sel_q, cfg_sel_d;
    logic [1:0]  cfg_reg_q, cfg_reg_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [7:0]  echo_cnt_q, echo_cnt_d;
    logic        cfg_done_q, cfg_done_d;
    logic        iocs_q, iocs_d;
    logic        iorw_q, iorw_d;
    logic [1:0]  ioaddr_q, ioaddr_d;
    logic [7:0]  dout_q, dout_d;
    logic [15:0] div_sel;

    always_comb begin
        state_d    = state_q;
        cfg_sel_d  = cfg_sel_q;
        cfg_reg_d  = cfg_reg_q;
        rx_byte_d  = rx_byte_q;
        echo_cnt_d = echo_cnt_q;
        cfg_done_d = cfg_done_q;

        case (state_q)
            ST_RESET:    state_d = ST_CFG_LOW;
            ST_CFG_LOW:  state_d = ST_CFG_HIGH;
            ST_CFG_HIGH: begin
                cfg_reg_d  = cfg_sel_q;
                cfg_done_d = 1'b1;
                state_d    = ST_POLL_RX;
            end
            ST_POLL_RX: begin
                if (databus_in[STAT_RDA]) begin
                    state_d = ST_READ_RX;
                end else if (br_sync_q != cfg_reg_q) begin
                    cfg_done_d = 1'b0;
                    state_d    = ST_CFG_LOW;
                end
            end
            ST_READ_RX: begin
                rx_byte_d = databus_in;
                state_d   = ST_POLL_TX;
            end
            ST_POLL_TX: begin
                if (databus_in[STAT_TBR]) state_d = ST_WRITE_TX;
            end
            ST_WRITE_TX: begin
                echo_cnt_d = echo_cnt_q + 8'd1;
                state_d    = ST_POLL_RX;
            end
            default:     state_d = ST_RESET;
        endcase

        // Divisor choice is frozen on entry so both bytes come from the same setting.
        if (state_d == ST_CFG_LOW) cfg_sel_d = br_sync_q;
        div_sel = div_lookup(cfg_sel_d);

        // Bus outputs are registered, so they are decoded from the state being entered.
        iocs_d   = 1'b1;
        iorw_d   = 1'b1;
        ioaddr_d = ADDR_STAT;
        dout_d   = 8'h00;
        case (state_d)
            ST_CFG_LOW: begin
                iorw_d   = 1'b0;
                ioaddr_d = ADDR_DBL;
                dout_d   = div_sel[7:0];
            end
            ST_CFG_HIGH: begin
                iorw_d   = 1'b0;
                ioaddr_d = ADDR_DBH;
                dout_d   = div_sel[15:8];
            end
            ST_READ_RX:  ioaddr_d = ADDR_BUF;
            ST_WRITE_TX: begin
                iorw_d   = 1'b0;
                ioaddr_d = ADDR_BUF;
                dout_d   = rx_byte_d;
            end
            ST_POLL_RX, ST_POLL_TX: ioaddr_d = ADDR_STAT;
            default: begin
                iocs_d   = 1'b0;
                ioaddr_d = ADDR_BUF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RESET;
            cfg_sel_q  <= 2'b00;
            cfg_reg_q  <= 2'b00;
            rx_byte_q  <= 8'h00;
            echo_cnt_q <= 8'h00;
            cfg_done_q <= 1'b0;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= ADDR_BUF;
            dout_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            cfg_sel_q  <= cfg_sel_d;
            cfg_reg_q  <= cfg_reg_d;
            rx_byte_q  <= rx_byte_d;
            echo_cnt_q <= echo_cnt_d;
            cfg_done_q <= cfg_done_d;
            iocs_q     <= iocs_d;
            iorw_q     <= iorw_d;
            ioaddr_q   <= ioaddr_d;
            dout_q     <= dout_d;
        end
    end

    assign iocs        = iocs_q;
    assign iorw        = iorw_q;
    assign ioaddr      = ioaddr_q;
    assign databus_out = dout_q;
    assign rx_byte     = rx_byte_q;
    assign echo_cnt    = echo_cnt_q;
    assign cfg_done    = cfg_done_q;

endmodule
